// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the elastic inter-stage pipeline registers of the MIPS core.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  // An all-zero instruction word is sll $0,$0,0, so a zeroed bundle is a nop.
  localparam logic [31:0] PIPE_NOP = 32'h0000_0000;

  localparam int FD_BUNDLE_W = 3 * 32;
  localparam int DE_BUNDLE_W = 6 * 32 + 5 + 1;
  localparam int EM_BUNDLE_W = 4 * 32 + 5 + 1;
  localparam int MW_BUNDLE_W = 4 * 32 + 5 + 1;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  // Count enabled cycles, stopping at the maximum value.
  always_ff @(posedge clk) begin
    if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register with a 2-entry skid buffer, flush and nop bubbles.
// Optional perf counters are built when PIPE_STAGE_PERF_EN is defined.
import pipe_pkg::*;

module pipe_skid_stage #(
  parameter int DATA_W = DE_BUNDLE_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [DATA_W-1:0] ZERO_BEAT = {DATA_W{1'b0}};

  pipe_state_t       state_r;
  logic [DATA_W-1:0] main_r;
  logic [DATA_W-1:0] skid_r;
  logic              in_fire_s;
  logic              out_fire_s;

  // Handshake outputs decode state only, so no input reaches an output combinationally.
  assign in_ready   = (state_r != TWO);
  assign out_valid  = (state_r != EMPTY);
  assign out_data   = main_r;
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;

  // Occupancy state and storage; emptied slots are zeroed so bubbles stay nops.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_r <= EMPTY;
      main_r  <= ZERO_BEAT;
      skid_r  <= ZERO_BEAT;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            main_r  <= in_data;
            state_r <= ONE;
          end
        end
        ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_r <= in_data;
          end else if (in_fire_s) begin
            skid_r  <= in_data;
            state_r <= TWO;
          end else if (out_fire_s) begin
            main_r  <= ZERO_BEAT;
            state_r <= EMPTY;
          end
        end
        TWO: begin
          if (out_fire_s) begin
            main_r  <= skid_r;
            skid_r  <= ZERO_BEAT;
            state_r <= ONE;
          end
        end
        default: begin
          state_r <= EMPTY;
          main_r  <= ZERO_BEAT;
          skid_r  <= ZERO_BEAT;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc_s;
  logic bubble_inc_s;

  assign stall_inc_s  = out_valid & ~out_ready;
  assign bubble_inc_s = ~out_valid;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (stall_inc_s),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (bubble_inc_s),
    .count (bubble_cnt)
  );
`else
  assign stall_cnt  = {CNT_W{1'b0}};
  assign bubble_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed-vector bench for pipe_skid_stage with a queue scoreboard and a separate output monitor.
module tb_pipe_skid_stage;

  localparam int DW = 198;
  localparam int CW = 4;
`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CW-1:0] EXP_STALL_SAT = 4'hF;
  localparam logic [CW-1:0] EXP_BUBBLE    = 4'h2;
`else
  localparam logic [CW-1:0] EXP_STALL_SAT = 4'h0;
  localparam logic [CW-1:0] EXP_BUBBLE    = 4'h0;
`endif

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [DW-1:0] in_data;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cnt, bubble_cnt;

  int            total = 0;
  int            bad = 0;
  logic          mon_en = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_d;

  pipe_skid_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs, check handshake at the falling edge, update the scoreboard at the edge.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy,
                      input logic fl, input logic rs, input logic exp_ir, input logic exp_ov);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
    @(negedge clk);
    chk("in_ready", {{(DW-1){1'b0}}, in_ready}, {{(DW-1){1'b0}}, exp_ir});
    chk("out_valid", {{(DW-1){1'b0}}, out_valid}, {{(DW-1){1'b0}}, exp_ov});
    @(posedge clk);
    if (rs || fl) exp_q.delete();
    else if (iv && exp_ir) exp_q.push_back(d);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", {{(DW-1){1'b0}}, in_ready}, {{(DW-1){1'b0}}, 1'b1});
    chk("rst_out_valid", {{(DW-1){1'b0}}, out_valid}, {DW{1'b0}});
    chk("rst_out_data", out_data, {DW{1'b0}});
    chk("rst_stall_cnt", {{(DW-CW){1'b0}}, stall_cnt}, {DW{1'b0}});
    chk("rst_bubble_cnt", {{(DW-CW){1'b0}}, bubble_cnt}, {DW{1'b0}});
  endtask

  // Monitor: every delivered beat must match the oldest expected beat; bubbles must be zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got %0h expected none", out_data);
        end else begin
          exp_d = exp_q.pop_front();
          chk("out_data", out_data, exp_d);
        end
      end else if (!out_valid) begin
        chk("bubble_zero", out_data, {DW{1'b0}});
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = {DW{1'b0}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // single beat, 1-cycle latency
    step(1'b1, 198'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 198'h0,    1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 198'h0,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // back-pressure: A, B absorbed, C waits until A drains
    step(1'b1, 198'hA0A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 198'hB0B, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 198'hC0C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 198'hC0C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 198'hC0C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 198'hD0D, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 198'h0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 198'h0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // flush while full
    step(1'b1, 198'hE0E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 198'hF0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 198'h606, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 198'h0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // flush with in_fire and out_fire: H delivered, I discarded
    step(1'b1, 198'h808, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 198'h909, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 198'h0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // reset while full
    step(1'b1, 198'h1A1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 198'h1B1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 198'h1C1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk); #1;

    // stall counter saturation, unaffected by flush
    step(1'b1, 198'h2C2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 198'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("stall_sat", {{(DW-CW){1'b0}}, stall_cnt}, {{(DW-CW){1'b0}}, EXP_STALL_SAT});
    chk("bubble_cnt", {{(DW-CW){1'b0}}, bubble_cnt}, {{(DW-CW){1'b0}}, EXP_BUBBLE});
    @(posedge clk); #1;
    step(1'b0, 198'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("stall_after_flush", {{(DW-CW){1'b0}}, stall_cnt}, {{(DW-CW){1'b0}}, EXP_STALL_SAT});
    chk("bubble_after_flush", {{(DW-CW){1'b0}}, bubble_cnt}, {{(DW-CW){1'b0}}, EXP_BUBBLE});
    @(posedge clk); #1;

    chk("drained", DW'(exp_q.size()), {DW{1'b0}});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
